// File: rtl/instr_decode_queue_pkg.sv
// instr_pkg: opcodes, class codes and the decoded-entry layout shared by decode and execute
package instr_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [1:0] {
      CLS_R = 2'd0,
      CLS_I = 2'd1,
      CLS_J = 2'd2
   } cls_t;

   // PC-width-independent part of a decoded word; pc and targets travel alongside
   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  fc;
      logic [15:0] imm16;
      logic [25:0] imm26;
      logic [31:0] imm_ext;
      cls_t        cls;
      logic        illegal;
   } dec_t;

   localparam int DEC_W = $bits(dec_t);

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                        OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW};
   endfunction

endpackage

// File: rtl/instr_decode_queue_if.sv
// instr_decode_queue_if: fetch-side beat, execute-side decoded head and flush
interface instr_decode_queue_if #(
   parameter int PC_W  = 32,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [5:0]      out_op;
   logic [4:0]      out_rs;
   logic [4:0]      out_rt;
   logic [4:0]      out_rd;
   logic [4:0]      out_shamt;
   logic [5:0]      out_fc;
   logic [15:0]     out_imm16;
   logic [25:0]     out_imm26;
   logic [31:0]     out_imm_ext;
   logic [PC_W-1:0] out_pc;
   logic [PC_W-1:0] out_btarget;
   logic [PC_W-1:0] out_jtarget;
   logic [1:0]      out_cls;
   logic            out_illegal;
   logic [CW-1:0]   out_count;

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt, out_fc,
             out_imm16, out_imm26, out_imm_ext, out_pc, out_btarget, out_jtarget,
             out_cls, out_illegal, out_count
   );

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt, out_fc,
             out_imm16, out_imm26, out_imm_ext, out_pc, out_btarget, out_jtarget,
             out_cls, out_illegal, out_count
   );
endinterface

// File: rtl/instr_decode_queue_field_decode.sv
// instr_field_decode: combinational split of a MIPS word plus immediate/target computation
module instr_field_decode
   import instr_pkg::*;
#(
   parameter int PC_W       = 32,
   parameter bit ZEXT_LOGIC = 1'b1
) (
   input  logic [31:0]     instr,
   input  logic [PC_W-1:0] pc,
   output dec_t            dec,
   output logic [PC_W-1:0] btarget,
   output logic [PC_W-1:0] jtarget
);
   logic [5:0]      op;
   logic [15:0]     imm16;
   logic [25:0]     imm26;
   logic [PC_W-1:0] pc4;
   logic            logic_op;

   assign op       = instr[31:26];
   assign imm16    = instr[15:0];
   assign imm26    = instr[25:0];
   assign pc4      = pc + PC_W'(4);
   assign logic_op = op == OP_ANDI || op == OP_ORI || op == OP_XORI;
   assign btarget  = pc4 + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};

   // upper pc bits only exist when the pc is wider than a jump region
   if (PC_W > 28) begin : g_jwide
      assign jtarget = {pc4[PC_W-1:28], imm26, 2'b00};
   end else begin : g_jnarrow
      assign jtarget = {imm26, 2'b00};
   end

   // field split, class and extended immediate
   always_comb begin
      dec         = '0;
      dec.op      = op;
      dec.rs      = instr[25:21];
      dec.rt      = instr[20:16];
      dec.rd      = instr[15:11];
      dec.shamt   = instr[10:6];
      dec.fc      = instr[5:0];
      dec.imm16   = imm16;
      dec.imm26   = imm26;
      dec.imm_ext = op == OP_LUI ? {imm16, 16'h0} :
                    (ZEXT_LOGIC && logic_op) ? {16'h0, imm16} :
                    {{16{imm16[15]}}, imm16};
      dec.cls     = op == OP_RTYPE ? CLS_R :
                    (op == OP_J || op == OP_JAL) ? CLS_J : CLS_I;
      dec.illegal = !is_legal(op);
   end
endmodule

// File: rtl/instr_decode_queue.sv
// instr_decode_queue: decode-at-push FIFO between fetch and execute with flush
module instr_decode_queue
   import instr_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int PC_W       = 32,
   parameter bit ZEXT_LOGIC = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   instr_decode_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   dec_t            in_dec;
   dec_t            head;
   logic [PC_W-1:0] in_bt;
   logic [PC_W-1:0] in_jt;
   dec_t            mem_dec [DEPTH];
   logic [PC_W-1:0] mem_pc  [DEPTH];
   logic [PC_W-1:0] mem_bt  [DEPTH];
   logic [PC_W-1:0] mem_jt  [DEPTH];

   instr_field_decode #(.PC_W(PC_W), .ZEXT_LOGIC(ZEXT_LOGIC)) u_decode (
      .instr   (bus.in_instr),
      .pc      (bus.in_pc),
      .dec     (in_dec),
      .btarget (in_bt),
      .jtarget (in_jt)
   );

   assign bus.in_ready  = count != CW'(DEPTH);
   assign bus.out_valid = count != '0;
   assign bus.out_count = count;
   assign push = bus.in_valid & bus.in_ready & ~bus.flush;
   assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

   // pointers and occupancy; flush empties the queue and drops this cycle's beat
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // payload storage needs no reset: nothing is visible until count says so
   always_ff @(posedge clk) begin
      if (push) begin
         mem_dec[wr_ptr] <= in_dec;
         mem_pc[wr_ptr]  <= bus.in_pc;
         mem_bt[wr_ptr]  <= in_bt;
         mem_jt[wr_ptr]  <= in_jt;
      end
   end

   assign head            = mem_dec[rd_ptr];
   assign bus.out_op      = head.op;
   assign bus.out_rs      = head.rs;
   assign bus.out_rt      = head.rt;
   assign bus.out_rd      = head.rd;
   assign bus.out_shamt   = head.shamt;
   assign bus.out_fc      = head.fc;
   assign bus.out_imm16   = head.imm16;
   assign bus.out_imm26   = head.imm26;
   assign bus.out_imm_ext = head.imm_ext;
   assign bus.out_cls     = head.cls;
   assign bus.out_illegal = head.illegal;
   assign bus.out_pc      = mem_pc[rd_ptr];
   assign bus.out_btarget = mem_bt[rd_ptr];
   assign bus.out_jtarget = mem_jt[rd_ptr];
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: directed checks of decode, FIFO handshake, flush and async reset
module tb_instr_decode_queue;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   instr_decode_queue_if #(.PC_W(32), .DEPTH(2)) bus ();
   instr_decode_queue_if #(.PC_W(32), .DEPTH(2)) bus0 ();

   instr_decode_queue #(.DEPTH(2), .PC_W(32), .ZEXT_LOGIC(1'b1)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
   instr_decode_queue #(.DEPTH(2), .PC_W(32), .ZEXT_LOGIC(1'b0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave)
   );

   assign bus0.flush     = bus.flush;
   assign bus0.in_valid  = bus.in_valid;
   assign bus0.in_instr  = bus.in_instr;
   assign bus0.in_pc     = bus.in_pc;
   assign bus0.out_ready = bus.out_ready;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
      tick();
   endtask

   task automatic push1(input logic [31:0] instr, input logic [31:0] pc);
      bus.out_ready = 1'b0;
      beat(instr, pc);
      bus.in_valid = 1'b0;
   endtask

   task automatic pop1();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b0;
      #3;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_count", bus.out_count, 0);
      chk("rst_ready", bus.in_ready, 1);
      #4 reset = 1'b1;
      tick();

      push1(32'h012A4020, 32'h00003000);
      chk("r_valid", bus.out_valid, 1);
      chk("r_op", bus.out_op, 6'h00);
      chk("r_rs", bus.out_rs, 9);
      chk("r_rt", bus.out_rt, 10);
      chk("r_rd", bus.out_rd, 8);
      chk("r_fc", bus.out_fc, 6'h20);
      chk("r_cls", bus.out_cls, 0);
      chk("r_ill", bus.out_illegal, 0);
      chk("r_count", bus.out_count, 1);
      pop1();
      chk("r_popped", bus.out_count, 0);

      push1(32'h1109FFFF, 32'h00003004);
      chk("beq_imm", bus.out_imm_ext, 32'hFFFFFFFF);
      chk("beq_bt", bus.out_btarget, 32'h00003004);
      chk("beq_cls", bus.out_cls, 1);
      pop1();

      push1(32'h3508F000, 32'h00003008);
      chk("ori_zext", bus.out_imm_ext, 32'h0000F000);
      chk("ori_sext", bus0.out_imm_ext, 32'hFFFFF000);
      pop1();

      push1(32'h3C081234, 32'h0000300C);
      chk("lui_imm", bus.out_imm_ext, 32'h12340000);
      pop1();

      push1(32'h08000C00, 32'h00003010);
      chk("j_cls", bus.out_cls, 2);
      chk("j_jt", bus.out_jtarget, 32'h00003000);
      chk("j_ill", bus.out_illegal, 0);
      pop1();

      push1(32'hFC000000, 32'h00003014);
      chk("bad_ill", bus.out_illegal, 1);
      chk("bad_cls", bus.out_cls, 1);
      pop1();
      chk("empty", bus.out_valid, 0);

      bus.out_ready = 1'b0;
      beat(32'h20010001, 32'h100);
      beat(32'h20020002, 32'h104);
      beat(32'h20030003, 32'h108);
      chk("full_count", bus.out_count, 2);
      chk("full_ready", bus.in_ready, 0);
      chk("full_head", bus.out_pc, 32'h100);

      bus.out_ready = 1'b1;
      beat(32'h20030003, 32'h108);
      chk("drain_count", bus.out_count, 1);
      chk("drain_head", bus.out_pc, 32'h104);
      beat(32'h20030003, 32'h108);
      chk("st_c_pc", bus.out_pc, 32'h108);
      chk("st_c_cnt", bus.out_count, 1);
      beat(32'h20040004, 32'h10C);
      chk("st_d_pc", bus.out_pc, 32'h10C);
      chk("st_d_imm", bus.out_imm16, 16'h0004);
      beat(32'h20050005, 32'h110);
      chk("st_e_pc", bus.out_pc, 32'h110);
      chk("st_e_cnt", bus.out_count, 1);

      bus.out_ready = 1'b0;
      beat(32'h20060006, 32'h114);
      chk("refill_cnt", bus.out_count, 2);
      chk("refill_head", bus.out_pc, 32'h110);

      bus.flush = 1'b1;
      beat(32'h20070007, 32'h118);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_count", bus.out_count, 0);
      chk("fl_valid", bus.out_valid, 0);
      chk("fl_ready", bus.in_ready, 1);

      push1(32'h20080008, 32'h11C);
      chk("post_fl_pc", bus.out_pc, 32'h11C);
      chk("post_fl_imm", bus.out_imm16, 16'h0008);
      chk("post_fl_cnt", bus.out_count, 1);

      push1(32'h20090009, 32'h120);
      chk("pre_rst_cnt", bus.out_count, 2);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_count", bus.out_count, 0);
      #2 reset = 1'b1;

      push1(32'h200A000A, 32'h124);
      chk("rel_valid", bus.out_valid, 1);
      chk("rel_pc", bus.out_pc, 32'h124);
      chk("rel_cnt", bus.out_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
